sd_sector_feeder: RTL
=====================

Name: sd_sector_feeder

Overview:
Upstream feeder for the SD-card SPI single-block write engine. It accepts a 16-bit word stream (camera or Ethernet payload), packs it into 256-word (512-byte) sectors in a ping-pong buffer, and issues one write per sector. For each sector it starts the write engine, supplies data words on the engine's word requests, and advances the sector address. It sits between the data source and the write engine, in the engine's clk_ref domain.

Parameters:
START_SEC, 32'd0, first sector address written after reset.
SEC_NUM, 32'd1024, number of sectors in the ring; address wraps to START_SEC after START_SEC+SEC_NUM-1.
WORDS_PER_SEC, 256, words per sector; fixed by the write engine, must not be overridden.

Ports:
clk_ref  in  1  sole clock, same clock as the write engine's clk_ref.
rst_n  in  1  reset, asynchronous, active-low.
sd_init_done  in  1  SD initialisation complete; no write starts while low.
din_valid  in  1  input word valid.
din  in  16  input word; first word of a sector becomes sector bytes 0 (MSB) and 1.
din_ready  out  1  high when a buffer can accept a word; words with din_valid=1 and din_ready=0 are dropped.
flush  in  1  single-cycle pulse; pads the partially filled sector with PAD 16'h0000 and commits it.
wr_busy  in  1  busy flag from the write engine.
wr_req  in  1  single-cycle word request from the write engine.
wr_start_en  out  1  write start level to the write engine; the engine detects its rising edge.
wr_sec_addr  out  32  sector address, stable while wr_start_en=1 and while wr_busy=1.
wr_data  out  16  word to the write engine.
sec_done_cnt  out  32  count of completed sectors, wraps at 2^32.
overflow  out  1  sticky; set on the first dropped word; cleared only by reset.
drop_cnt  out  16  dropped-word count; available only with the optional feature.

Behaviour:
- Reset values: din_ready=0, wr_start_en=0, wr_sec_addr=START_SEC, wr_data=0, sec_done_cnt=0, overflow=0, drop_cnt=0. Both buffers empty, fill pointer = buffer 0, read state = IDLE.
- Reset mid-operation discards all buffered data. The write engine is reset by the same rst_n.
- Fill side:
  - din_ready = (fill buffer not full) and not in pad mode.
  - Each accepted word is written at fill index 0..255.
  - At index 255, the buffer is marked full, the fill pointer toggles, and the index clears.
  - din_ready goes low on the next cycle if the other buffer is still full.
- flush:
  - Ignored if the fill index is 0.
  - Otherwise the block enters pad mode: it writes PAD one word per cycle until index 255, then marks the buffer full as above.
  - din_ready=0 during pad mode; flush pulses during pad mode are ignored.
- Read-side FSM:
  - IDLE: if sd_init_done=1, wr_busy=0, and the read buffer is full, load the wr_data prefetch with word 0 and go to START.
  - START: wr_start_en=1. Stay until wr_busy is sampled 1, then wr_start_en=0 and go to XFER. The write engine's wr_busy rises 3 cycles after wr_start_en.
  - XFER: at every edge with wr_req=1, drive the prefetched word on wr_data and prefetch the next word. Word k must appear on wr_data at the edge after the k-th wr_req is sampled; it holds until the next wr_req. Exactly 256 wr_req pulses per sector. When wr_busy is sampled 0, go to DONE.
  - DONE (1 cycle): mark the read buffer empty, toggle the read pointer, sec_done_cnt+1, and advance wr_sec_addr by 1 with wrap to START_SEC. Go to IDLE.
- wr_start_en is low for at least 2 cycles between sectors, so each sector produces a new rising edge at the engine.
- Simultaneous events:
  - The fill side may fill one buffer in the same cycle the read side releases the other; release wins for din_ready on the next cycle.
  - din_valid coinciding with the full transition is accepted.
- A wr_req pulse beyond 256 in one sector: wr_data repeats the last word; the event must not corrupt the next sector.

Optional Feature:
SD_FEED_DROP_CNT_EN:
- Defined: drop_cnt increments on each dropped word and saturates at 16'hFFFF.
- Undefined: drop_cnt is tied to 0 and no counter logic is built.
- overflow behaves the same in both builds.

Test Plan:
- 256 words 0x0000..0x00FF, sd_init_done=1, engine model -> one wr_start_en rise; wr_sec_addr=START_SEC; wr_data sequence 0x0000..0x00FF; sec_done_cnt=1; next wr_sec_addr=START_SEC+1.
- Sector requested with sd_init_done=0 for 100 cycles -> wr_start_en stays 0; start occurs within 2 cycles of sd_init_done rising.
- 3 sectors sent with the engine stalled (wr_busy held high) -> third-sector words dropped; din_ready=0; overflow=1; drop_cnt=256 with the macro defined, 0 without it.
- 10 words then a flush pulse -> 256 words written: 10 data words then 246 words of 0x0000; din_ready=0 during the pad.
- SEC_NUM=2, 3 sectors -> addresses START_SEC, START_SEC+1, START_SEC.
- rst_n asserted mid-XFER after 100 wr_req pulses -> all outputs at reset values; next full sector uses START_SEC.

Source files
------------

// File: rtl/sd_sector_feeder.sv
// Packs a 16-bit word stream into 256-word ping-pong sectors and drives the SD single-block write engine.
// Optional dropped-word counter: define SD_FEED_DROP_CNT_EN.
module sd_sector_feeder #(
    parameter logic [31:0] START_SEC     = 32'd0,
    parameter logic [31:0] SEC_NUM       = 32'd1024,
    parameter int          WORDS_PER_SEC = 256
) (
    input  logic        clk_ref,
    input  logic        rst_n,
    input  logic        sd_init_done,
    input  logic        din_valid,
    input  logic [15:0] din,
    output logic        din_ready,
    input  logic        flush,
    input  logic        wr_busy,
    input  logic        wr_req,
    output logic        wr_start_en,
    output logic [31:0] wr_sec_addr,
    output logic [15:0] wr_data,
    output logic [31:0] sec_done_cnt,
    output logic        overflow,
    output logic [15:0] drop_cnt
);
    // state | meaning
    // IDLE  | waiting for a full read buffer, init done and engine idle
    // START | wr_start_en high until the engine reports busy
    // XFER  | serving word requests from the prefetch register
    // DONE  | release buffer, bump address and sector count
    typedef enum logic [1:0] {IDLE, START, XFER, DONE} rd_state_t;

    localparam logic [7:0]  LAST_IDX = 8'(WORDS_PER_SEC - 1);
    localparam logic [8:0]  WORDS    = 9'(WORDS_PER_SEC);
    localparam logic [31:0] LAST_SEC = START_SEC + SEC_NUM - 32'd1;
    localparam logic [15:0] PAD      = 16'h0000;

    logic [15:0] mem [0:511];
    logic        mem_we;
    logic [8:0]  mem_waddr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;

    rd_state_t   state_q, state_d;
    logic [1:0]  full_q, full_d;
    logic        fill_ptr_q, fill_ptr_d;
    logic [7:0]  fill_idx_q, fill_idx_d;
    logic        pad_q, pad_d;
    logic        din_ready_q, din_ready_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic [8:0]  rd_idx_q, rd_idx_d;
    logic [15:0] pref_q, pref_d;
    logic [15:0] wr_data_q, wr_data_d;
    logic        wr_start_en_q, wr_start_en_d;
    logic [31:0] sec_addr_q, sec_addr_d;
    logic [31:0] sec_done_cnt_q, sec_done_cnt_d;
    logic        overflow_q, overflow_d;
    logic        accept;
    logic        drop;

    assign accept    = din_valid & din_ready_q;
    assign drop      = din_valid & ~din_ready_q;
    assign mem_rdata = mem[{rd_ptr_q, rd_idx_q[7:0]}];

    always_comb begin
        full_d         = full_q;
        fill_ptr_d     = fill_ptr_q;
        fill_idx_d     = fill_idx_q;
        pad_d          = pad_q;
        rd_ptr_d       = rd_ptr_q;
        rd_idx_d       = rd_idx_q;
        pref_d         = pref_q;
        wr_data_d      = wr_data_q;
        wr_start_en_d  = wr_start_en_q;
        sec_addr_d     = sec_addr_q;
        sec_done_cnt_d = sec_done_cnt_q;
        state_d        = state_q;
        overflow_d     = overflow_q | drop;
        mem_we         = 1'b0;
        mem_waddr      = {fill_ptr_q, fill_idx_q};
        mem_wdata      = din;

        if (pad_q || accept) begin
            mem_we    = 1'b1;
            mem_wdata = pad_q ? PAD : din;
            if (fill_idx_q == LAST_IDX) begin
                full_d[fill_ptr_q] = 1'b1;
                fill_ptr_d         = ~fill_ptr_q;
                fill_idx_d         = 8'd0;
                pad_d              = 1'b0;
            end else begin
                fill_idx_d = fill_idx_q + 8'd1;
            end
        end
        // a flush that lands on an empty sector (including one just completed) has nothing to pad
        if (flush && !pad_q && fill_idx_d != 8'd0) begin
            pad_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (sd_init_done && !wr_busy && full_q[rd_ptr_q]) begin
                    pref_d        = mem_rdata;
                    rd_idx_d      = 9'd1;
                    wr_start_en_d = 1'b1;
                    state_d       = START;
                end
            end
            START: begin
                if (wr_busy) begin
                    wr_start_en_d = 1'b0;
                    state_d       = XFER;
                end
            end
            XFER: begin
                if (wr_req) begin
                    wr_data_d = pref_q;
                    // past the last word the prefetch holds, so extra requests repeat it
                    if (rd_idx_q != WORDS) begin
                        pref_d   = mem_rdata;
                        rd_idx_d = rd_idx_q + 9'd1;
                    end
                end
                if (!wr_busy) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                full_d[rd_ptr_q] = 1'b0;
                rd_ptr_d         = ~rd_ptr_q;
                rd_idx_d         = 9'd0;
                sec_done_cnt_d   = sec_done_cnt_q + 32'd1;
                sec_addr_d       = (sec_addr_q == LAST_SEC) ? START_SEC : sec_addr_q + 32'd1;
                state_d          = IDLE;
            end
            default: state_d = IDLE;
        endcase

        din_ready_d = ~full_d[fill_ptr_d] & ~pad_d;
    end

    always_ff @(posedge clk_ref) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk_ref or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            full_q         <= 2'b00;
            fill_ptr_q     <= 1'b0;
            fill_idx_q     <= 8'd0;
            pad_q          <= 1'b0;
            din_ready_q    <= 1'b0;
            rd_ptr_q       <= 1'b0;
            rd_idx_q       <= 9'd0;
            pref_q         <= 16'h0000;
            wr_data_q      <= 16'h0000;
            wr_start_en_q  <= 1'b0;
            sec_addr_q     <= START_SEC;
            sec_done_cnt_q <= 32'd0;
            overflow_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            full_q         <= full_d;
            fill_ptr_q     <= fill_ptr_d;
            fill_idx_q     <= fill_idx_d;
            pad_q          <= pad_d;
            din_ready_q    <= din_ready_d;
            rd_ptr_q       <= rd_ptr_d;
            rd_idx_q       <= rd_idx_d;
            pref_q         <= pref_d;
            wr_data_q      <= wr_data_d;
            wr_start_en_q  <= wr_start_en_d;
            sec_addr_q     <= sec_addr_d;
            sec_done_cnt_q <= sec_done_cnt_d;
            overflow_q     <= overflow_d;
        end
    end

`ifdef SD_FEED_DROP_CNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop && drop_cnt_q != 16'hFFFF) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_ref or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_q <= 16'h0000;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`else
    assign drop_cnt = 16'h0000;
`endif

    assign din_ready    = din_ready_q;
    assign wr_start_en  = wr_start_en_q;
    assign wr_sec_addr  = sec_addr_q;
    assign wr_data      = wr_data_q;
    assign sec_done_cnt = sec_done_cnt_q;
    assign overflow     = overflow_q;

endmodule
